multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// Control FSM for the multicycle RV32I core: sequences the shared ALU, single instr/data memory
// port and register file one step per cycle for lw, sw, R-type, I-type ALU, beq and jal.
// Drives the mux selects and write enables of the multicycle datapath.
// ALUOp feeds the existing ALU decoder. Adds memory-ready stalls, a sticky illegal-opcode trap and a retired-instruction counter.
// PARAMETERS
// MEM_HANDSHAKE  1   1: FETCH/MEMREAD/MEMWRITE wait for MemReady; 0: MemReady ignored (treated as 1)
// CNT_W          32  width of InstRet counter
// PORTS
// clk        in   1      single clock, rising edge
// reset      in   1      asynchronous, active-high
// Opcode     in   7      instr[6:0] from instruction register
// Zero       in   1      ALU zero flag
// MemReady   in   1      memory completes current access this cycle
// PCWrite    out  1      PC register enable
// AdrSrc     out  1      0: memory address = PC, 1: address = ALUOut/Result
// MemWrite   out  1      memory write strobe
// IRWrite    out  1      instruction/OldPC register enable
// RegWrite   out  1      register file write enable
// ResultSrc  out  2      00 ALUOut, 01 Data, 10 ALUResult
// ALUSrcA    out  2      00 PC, 01 OldPC, 10 rs1
// ALUSrcB    out  2      00 rs2, 01 ImmExt, 10 const 4
// ALUOp      out  2      00 add, 01 sub(beq), 10 funct-decoded
// ImmSrc     out  2      00 I, 01 S, 10 B, 11 J (from Opcode, combinational)
// Illegal    out  1      sticky: unsupported opcode decoded
// InstRet    out  CNT_W  retired-instruction count
// BEHAVIOUR
// - Reset (async): state=FETCH, InstRet=0, Illegal=0. While reset=1, PCWrite/IRWrite/RegWrite/MemWrite=0.
// - Outputs are Moore from state, except the gated enables below. Any select not listed for a state = 00/0 (never x).
// - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//   IRWrite and PCWrite are 1 only when MemReady. Advance to DECODE on MemReady, else hold.
// - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch target). Next state by Opcode:
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; other -> TRAP.
// - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
// - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then -> MEMWB.
// - MEMWB: ResultSrc=01, RegWrite=1. Then -> FETCH.
// - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in state. Hold until MemReady, then -> FETCH.
// - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then -> ALUWB.
// - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then -> ALUWB.
// - ALUWB: ResultSrc=00, RegWrite=1. Then -> FETCH.
// - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = Zero (sampled this cycle). Then -> FETCH.
// - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Then -> ALUWB (rd = PC+4).
// - TRAP: all enables 0, Illegal=1. Stays in TRAP until reset.
// - Latency in cycles, MemReady=1: lw 5, sw 4, R/I 4, beq 3, jal 4. Each MemReady=0 cycle adds 1.
// - InstRet += 1 on the cycle an instruction retires: MEMWB, ALUWB, BEQ, MEMWRITE&&MemReady.
//   JAL retires in its ALUWB. Wraps 2^CNT_W-1 -> 0. Frozen in TRAP.
// - MemReady outside FETCH/MEMREAD/MEMWRITE is ignored.
// - Reset asserted mid-instruction aborts it immediately: no further enable pulse, no InstRet increment.
// - ImmSrc: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
// STRUCTURE
// - Package riscv_ctrl_pkg:
//   - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP)
//   - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
//   - ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings
// - One sub-module, instr_decoder: Opcode -> ImmSrc (pure combinational, reused by datapath tests).
// - Main body: state register, next-state logic, output logic, InstRet counter.
// TESTING
// 1. add (0110011), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB. RegWrite=1 in cycle 4 only. InstRet 0->1.
// 2. lw, MemReady low 2 cycles in MEMREAD -> 7 cycles total. AdrSrc=1 throughout MEMREAD. RegWrite once. InstRet+1.
// 3. beq, Zero=1 -> PCWrite=1 in BEQ. Repeat with Zero=0 -> PCWrite=0. ALUOp=01 both times.
// 4. jal -> ImmSrc=11, PCWrite in JAL, RegWrite in ALUWB. 4 cycles. InstRet+1.
// 5. Opcode 0000000 -> TRAP. Illegal=1, all enables 0 for 20 cycles. Reset -> FETCH, Illegal=0, InstRet=0.
// 6. CNT_W=4, 16 R-type instructions -> InstRet wraps 15->0.
//    Async reset asserted in MEMWRITE -> MemWrite=0 same cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM state
// encoding, supported opcodes and the select/ALUOp/ImmSrc encodings
// that the datapath muxes expect.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the multicycle datapath.
// master: controller side (consumes Opcode/Zero/MemReady, drives controls).
// slave : datapath side (drives Opcode/Zero/MemReady, consumes controls).
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [6:0]       Opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ImmSrc;
  logic             Illegal;
  logic [CNT_W-1:0] InstRet;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet
  );
endinterface

// File: rtl/multicycle_controller_instr_decoder.sv
// Opcode -> immediate format select. Purely combinational so the
// datapath tests can reuse it standalone.
// Ports: opcode (in, 7) instr[6:0]; imm_src (out, 2) 00 I, 01 S, 10 B, 11 J.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  // Immediate format per opcode; unsupported opcodes fall back to I.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_LW:   imm_src = IMM_I;
      OP_I:    imm_src = IMM_I;
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Ports: clk, reset (async, active-high); bus (master modport): Opcode,
// Zero, MemReady in; PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
// ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet out.
// Selects are Moore from the state register; write enables are
// additionally gated by reset so an abort never leaks a pulse.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.master bus
);

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] inst_ret_r;
  logic             mem_ready_s;
  logic             retire_s;
  logic             pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s;
  logic [1:0]       result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

  assign mem_ready_s = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  instr_decoder u_instr_decoder (
    .opcode  (bus.Opcode),
    .imm_src (bus.ImmSrc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= FETCH;
    else       state_r <= next_s;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    next_s       = state_r;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    retire_s     = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RS2;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        ir_write_s   = mem_ready_s;
        pc_write_s   = mem_ready_s;
        if (mem_ready_s) next_s = DECODE;
        else             next_s = FETCH;
      end
      DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (bus.Opcode)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_R:         next_s = EXECR;
          OP_I:         next_s = EXECI;
          OP_BEQ:       next_s = BEQ;
          OP_JAL:       next_s = JAL;
          default:      next_s = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        if (bus.Opcode == OP_LW) next_s = MEMREAD;
        else                     next_s = MEMWRITE;
      end
      MEMREAD: begin
        adr_src_s = 1'b1;
        if (mem_ready_s) next_s = MEMWB;
        else             next_s = MEMREAD;
      end
      MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_s       = FETCH;
      end
      MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = mem_ready_s;
        if (mem_ready_s) next_s = FETCH;
        else             next_s = MEMWRITE;
      end
      EXECR: begin
        alu_src_a_s = SRCA_RS1;
        alu_op_s    = ALUOP_FUNCT;
        next_s      = ALUWB;
      end
      EXECI: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_FUNCT;
        next_s      = ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        next_s      = FETCH;
      end
      BEQ: begin
        alu_src_a_s = SRCA_RS1;
        alu_op_s    = ALUOP_SUB;
        pc_write_s  = bus.Zero;
        retire_s    = 1'b1;
        next_s      = FETCH;
      end
      JAL: begin
        // Target was computed in DECODE; ALU now forms PC+4 for rd.
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_FOUR;
        pc_write_s  = 1'b1;
        next_s      = ALUWB;
      end
      TRAP:    next_s = TRAP;
      default: next_s = FETCH;
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         inst_ret_r <= '0;
    else if (retire_s) inst_ret_r <= inst_ret_r + CNT_W'(1);
    else               inst_ret_r <= inst_ret_r;
  end

  assign bus.PCWrite   = pc_write_s  & ~reset;
  assign bus.IRWrite   = ir_write_s  & ~reset;
  assign bus.RegWrite  = reg_write_s & ~reset;
  assign bus.MemWrite  = mem_write_s & ~reset;
  assign bus.AdrSrc    = adr_src_s;
  assign bus.ResultSrc = result_src_s;
  assign bus.ALUSrcA   = alu_src_a_s;
  assign bus.ALUSrcB   = alu_src_b_s;
  assign bus.ALUOp     = alu_op_s;
  // TRAP is absorbing until reset, so this is sticky by construction.
  assign bus.Illegal   = (state_r == TRAP);
  assign bus.InstRet   = inst_ret_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a 32-bit-counter instance
// plus a 4-bit-counter instance fed the same inputs for the wrap test.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) b ();
  multicycle_controller_if #(.CNT_W(4))  b4 ();

  assign b4.Opcode   = b.Opcode;
  assign b4.Zero     = b.Zero;
  assign b4.MemReady = b.MemReady;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(b));
  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Illegal}
  logic [15:0] obs;
  assign obs = {b.PCWrite, b.AdrSrc, b.MemWrite, b.IRWrite, b.RegWrite, b.ResultSrc,
                b.ALUSrcA, b.ALUSrcB, b.ALUOp, b.ImmSrc, b.Illegal};

  function automatic logic [15:0] ctl(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic rw, input logic [1:0] res, input logic [1:0] sa,
      input logic [1:0] sb, input logic [1:0] op, input logic [1:0] imm, input logic ill);
    return {pcw, adr, mw, irw, rw, res, sa, sb, op, imm, ill};
  endfunction

  // Expected control word per state, hand-derived from the state table.
  function automatic logic [15:0] v_fetch(input logic r, input logic [1:0] imm);
    return ctl(r, 1'b0, 1'b0, r, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0);
  endfunction
  function automatic logic [15:0] v_decode(input logic [1:0] imm);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0);
  endfunction
  function automatic logic [15:0] v_memadr(input logic [1:0] imm);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0);
  endfunction
  function automatic logic [15:0] v_memread();
    return ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] v_memwb();
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] v_memwrite();
    return ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
  endfunction
  function automatic logic [15:0] v_execr();
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] v_execi();
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] v_aluwb(input logic [1:0] imm);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0);
  endfunction
  function automatic logic [15:0] v_beq(input logic z);
    return ctl(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0);
  endfunction
  function automatic logic [15:0] v_jal();
    return ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 1'b0);
  endfunction
  function automatic logic [15:0] v_trap(input logic [1:0] imm);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Check the control word 1ns after inputs settle, then advance one cycle.
  task automatic cyc(input string tag, input logic [15:0] e);
    #1;
    chk(tag, {16'h0000, obs}, {16'h0000, e});
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset      = 1'b1;
    b.Opcode   = OP_R;
    b.Zero     = 1'b0;
    b.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    // Reset: FETCH selects, enables gated off, counters clear.
    chk("rst_instret", b.InstRet, 32'd0);
    cyc("rst_ctl", v_fetch(1'b0, 2'b00));
    reset = 1'b0;

    // 1. add
    cyc("add_fetch", v_fetch(1'b1, 2'b00));
    cyc("add_decode", v_decode(2'b00));
    cyc("add_execr", v_execr());
    chk("add_ret_pre", b.InstRet, 32'd0);
    cyc("add_aluwb", v_aluwb(2'b00));
    chk("add_ret", b.InstRet, 32'd1);

    // 2. lw with two stall cycles in MEMREAD
    b.Opcode = OP_LW;
    cyc("lw_fetch", v_fetch(1'b1, 2'b00));
    cyc("lw_decode", v_decode(2'b00));
    cyc("lw_memadr", v_memadr(2'b00));
    b.MemReady = 1'b0;
    cyc("lw_memrd0", v_memread());
    cyc("lw_memrd1", v_memread());
    b.MemReady = 1'b1;
    cyc("lw_memrd2", v_memread());
    chk("lw_ret_pre", b.InstRet, 32'd1);
    cyc("lw_memwb", v_memwb());
    chk("lw_ret", b.InstRet, 32'd2);

    // sw with a stalled fetch and a stalled write
    b.Opcode   = OP_SW;
    b.MemReady = 1'b0;
    cyc("sw_fetch_wait", v_fetch(1'b0, 2'b01));
    b.MemReady = 1'b1;
    cyc("sw_fetch", v_fetch(1'b1, 2'b01));
    cyc("sw_decode", v_decode(2'b01));
    cyc("sw_memadr", v_memadr(2'b01));
    b.MemReady = 1'b0;
    cyc("sw_memwr0", v_memwrite());
    chk("sw_ret_stall", b.InstRet, 32'd2);
    b.MemReady = 1'b1;
    cyc("sw_memwr1", v_memwrite());
    chk("sw_ret", b.InstRet, 32'd3);

    // 3. beq taken / not taken
    b.Opcode = OP_BEQ;
    cyc("beq1_fetch", v_fetch(1'b1, 2'b10));
    cyc("beq1_decode", v_decode(2'b10));
    b.Zero = 1'b1;
    cyc("beq1_taken", v_beq(1'b1));
    chk("beq1_ret", b.InstRet, 32'd4);
    b.Zero = 1'b0;
    cyc("beq0_fetch", v_fetch(1'b1, 2'b10));
    cyc("beq0_decode", v_decode(2'b10));
    cyc("beq0_not", v_beq(1'b0));
    chk("beq0_ret", b.InstRet, 32'd5);

    // 4. jal
    b.Opcode = OP_JAL;
    cyc("jal_fetch", v_fetch(1'b1, 2'b11));
    cyc("jal_decode", v_decode(2'b11));
    cyc("jal_jal", v_jal());
    chk("jal_ret_pre", b.InstRet, 32'd5);
    cyc("jal_aluwb", v_aluwb(2'b11));
    chk("jal_ret", b.InstRet, 32'd6);

    // I-type, MemReady low in DECODE must be ignored
    b.Opcode = OP_I;
    cyc("addi_fetch", v_fetch(1'b1, 2'b00));
    b.MemReady = 1'b0;
    cyc("addi_decode", v_decode(2'b00));
    b.MemReady = 1'b1;
    cyc("addi_execi", v_execi());
    cyc("addi_aluwb", v_aluwb(2'b00));
    chk("addi_ret", b.InstRet, 32'd7);

    // 5. illegal opcode -> TRAP, sticky for 20 cycles
    b.Opcode = 7'b0000000;
    cyc("ill_fetch", v_fetch(1'b1, 2'b00));
    cyc("ill_decode", v_decode(2'b00));
    for (int i = 0; i < 20; i++) begin
      b.Zero     = i[0];
      b.MemReady = ~i[1];
      cyc("trap_hold", v_trap(2'b00));
    end
    chk("trap_ret", b.InstRet, 32'd7);
    reset = 1'b1;
    #1;
    chk("trap_rst_ill", {31'd0, b.Illegal}, 32'd0);
    chk("trap_rst_ret", b.InstRet, 32'd0);
    b.Zero     = 1'b0;
    b.MemReady = 1'b1;
    cyc("trap_rst_ctl", v_fetch(1'b0, 2'b00));
    reset = 1'b0;

    // 6. 16 R-types: 4-bit counter wraps 15 -> 0
    b.Opcode = OP_R;
    for (int n = 1; n <= 16; n++) begin
      repeat (4) @(posedge clk);
      #2;
      if (n == 15) chk("wrap_15", {28'd0, b4.InstRet}, 32'd15);
      else if (n == 16) chk("wrap_0", {28'd0, b4.InstRet}, 32'd0);
      else chk("wrap_step", {28'd0, b4.InstRet}, n);
    end
    chk("wide_16", b.InstRet, 32'd16);

    // Async reset in MEMWRITE kills MemWrite in the same cycle
    b.Opcode = OP_SW;
    cyc("abort_fetch", v_fetch(1'b1, 2'b01));
    cyc("abort_decode", v_decode(2'b01));
    cyc("abort_memadr", v_memadr(2'b01));
    b.MemReady = 1'b0;
    #1;
    chk("abort_mw_pre", {31'd0, b.MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_mw", {31'd0, b.MemWrite}, 32'd0);
    chk("abort_ret", b.InstRet, 32'd0);
    cyc("abort_ctl", v_fetch(1'b0, 2'b01));
    chk("abort_ret_hold", b.InstRet, 32'd0);
    reset = 1'b0;
    b.MemReady = 1'b1;
    cyc("post_fetch", v_fetch(1'b1, 2'b01));
    cyc("post_decode", v_decode(2'b01));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
